// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM states, counter sizing and WIDTH limits for the bit-serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
  function automatic int cnt_w(input int w);
    return ($clog2(w) > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: combinational full adder
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out (majority)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one full adder over WIDTH-bit operands, LSB first
//   clk, rst_n     : clock, async active-low reset
//   start          : request, honoured in IDLE or DONE
//   a, b, cin      : operands, captured on the accepting edge
//   busy, done     : high in RUN / one-cycle strobe in DONE
//   sum, cout      : registered result, held until the next completion
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_w(WIDTH);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH out of range");
  end
  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_a, shift_b, shift_s, s_nx;
  logic [CW-1:0]    cnt;
  logic             carry, s, co, last, load;
  fa_cell u_fa (.a(shift_a[0]), .b(shift_b[0]), .ci(carry), .s(s), .co(co));
  // sum bits enter from the MSB end so the LSB lands at bit 0 after WIDTH steps
  if (WIDTH == 1) begin : g_w1
    assign s_nx = s;
  end else begin : g_wn
    assign s_nx = {s, shift_s[WIDTH-1:1]};
  end
  assign last = cnt == CW'(WIDTH - 1);
  assign load = start && state != RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_nx = IDLE;
    if (load) state_nx = RUN;
    else if (state == RUN) state_nx = last ? DONE : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      shift_s <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      shift_a <= a;
      shift_b <= b;
      carry   <= cin;
      cnt     <= '0;
    end else if (state == RUN) begin
      shift_a <= shift_a >> 1;
      shift_b <= shift_b >> 1;
      shift_s <= s_nx;
      carry   <= co;
      cnt     <= cnt + CW'(1);
      if (last) begin
        sum  <= s_nx;
        cout <= co;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl against an arithmetic a+b+cin model
module tb_serial_add_ctrl;
  logic       clk = 0, rst_n = 0;
  logic       start = 0, cin = 0, busy, done, cout;
  logic [7:0] a = 0, b = 0, sum;
  logic       start1 = 0, cin1 = 0, busy1, done1, cout1;
  logic [0:0] a1 = 0, b1 = 0, sum1;
  int checks = 0, errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout));
  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic op8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    logic [8:0] ref_v;
    int i, bc;
    ref_v = 9'(va) + 9'(vb) + 9'(vc);
    @(negedge clk);
    start = 1; a = va; b = vb; cin = vc;
    @(negedge clk);
    start = 0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    bc = 0;
    for (i = 1; i < 20; i++) begin
      if (done) break;
      if (busy) bc++;
      @(negedge clk);
    end
    chk("done_latency", i, 9);
    chk("busy_cycles", bc, 8);
    chk("sum", sum, ref_v[7:0]);
    chk("cout", cout, ref_v[8]);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
    chk("sum_hold", sum, ref_v[7:0]);
    chk("cout_hold", cout, ref_v[8]);
  endtask

  task automatic op1(input logic va, input logic vb, input logic vc);
    logic [1:0] ref_v;
    ref_v = 2'(va) + 2'(vb) + 2'(vc);
    @(negedge clk);
    start1 = 1; a1 = va; b1 = vb; cin1 = vc;
    @(negedge clk);
    start1 = 0; a1 = ~va; b1 = ~vb; cin1 = ~vc;
    chk("w1_busy", busy1, 1);
    chk("w1_not_done", done1, 0);
    @(negedge clk);
    chk("w1_done", done1, 1);
    chk("w1_sum", sum1, ref_v[0]);
    chk("w1_cout", cout1, ref_v[1]);
    @(negedge clk);
    chk("w1_done_clear", done1, 0);
  endtask

  initial begin
    logic [7:0] pa1, pb1, pa2, pb2;
    logic [8:0] e1, e2;
    int d1, d2, dn;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_w1_sum", sum1, 0);
    rst_n = 1;
    op8(8'hA5, 8'h3C, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);
    repeat (12) op8(8'($urandom), 8'($urandom), 1'($urandom));
    // start during RUN must be ignored
    @(negedge clk);
    start = 1; a = 8'h01; b = 8'h02; cin = 0;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    start = 1; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 0;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        dn++;
        if (dn == 1) begin
          chk("ignored_sum", sum, 8'h03);
          chk("ignored_cout", cout, 0);
        end
      end
      @(negedge clk);
    end
    chk("ignored_done_count", dn, 1);
    // back-to-back with start held high
    pa1 = 8'($urandom); pb1 = 8'($urandom); pa2 = 8'($urandom); pb2 = 8'($urandom);
    e1 = 9'(pa1) + 9'(pb1);
    e2 = 9'(pa2) + 9'(pb2) + 9'd1;
    @(negedge clk);
    start = 1; a = pa1; b = pb1; cin = 0;
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (d1 >= 0 && d2 < 0 && k == d1 + 1) chk("b2b_no_idle", busy, 1);
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
          chk("b2b_sum1", sum, e1[7:0]);
          chk("b2b_cout1", cout, e1[8]);
          a = pa2; b = pb2; cin = 1;
        end else if (d2 < 0) begin
          d2 = k;
          chk("b2b_sum2", sum, e2[7:0]);
          chk("b2b_cout2", cout, e2[8]);
          start = 0;
        end
      end
    end
    start = 0;
    chk("b2b_first_latency", d1, 9);
    chk("b2b_gap", d2 - d1, 9);
    // asynchronous reset mid-run
    op8(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    start = 1; a = 8'h77; b = 8'h11; cin = 0;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("no_done_after_abort", dn, 0);
    op8(8'h77, 8'h11, 1'b0);
    // WIDTH=1 build
    op1(1'b1, 1'b1, 1'b1);
    repeat (4) op1(1'($urandom), 1'($urandom), 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller: sequences one shared full-adder cell over two WIDTH-bit operands, one bit per clock, LSB first. It accepts an operand pair on a start pulse, runs WIDTH add steps while holding the carry in a flop, and publishes the sum and carry-out with a one-cycle done strobe. It sits between operand sources and any consumer that trades latency for area, replacing a WIDTH-bit ripple adder with a single full adder.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

- clk  in  1  single clock; all flops on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; the only reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- cin  in  1  carry-in; sampled on the accepting edge only.
- busy  out  1  high in RUN; reset 0.
- done  out  1  one-cycle strobe, high in DONE; reset 0.
- sum  out  WIDTH  registered result; reset 0; holds until the next completion.
- cout  out  1  registered final carry; reset 0; holds like sum.

## Operation
- States: IDLE, RUN, DONE.
  - Encoding is free; busy and done are decoded Moore outputs.
- IDLE: on start=1, load shift_a<=a, shift_b<=b, carry<=cin, cnt<=0, and go to RUN. On start=0, stay in IDLE.
- RUN: each cycle, the full-adder cell takes shift_a[0], shift_b[0] and carry.
  - The sum bit shifts into shift_s from the MSB end, so shift_s <= {s, shift_s[WIDTH-1:1]}.
  - shift_a and shift_b shift right, zero-filled.
  - carry <= co; cnt <= cnt+1.
- RUN exit: on the cycle where cnt==WIDTH-1, the step completes as usual. In the same edge:
  - sum <= {s, shift_s[WIDTH-1:1]};
  - cout <= co;
  - go to DONE.
- DONE: lasts exactly one cycle.
  - start=1: reload exactly as from IDLE and go to RUN (back-to-back, no idle gap).
  - start=0: go to IDLE.
- start while in RUN is ignored: no queuing, no effect on operands in flight.
- Counter width is clog2(WIDTH) with a minimum of 1. WIDTH=1 exits RUN after a single step.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-operation (any state): the block returns to IDLE.
  - busy, done, sum, cout, shift registers, carry and cnt all clear to 0.
  - No done is produced for the aborted operation.

## Timing
- Let E0 be the edge that accepts start.
- busy is high for the WIDTH cycles after E0 (edges E1..E_WIDTH are the add steps).
- done is high for exactly one cycle, after edge E_WIDTH and before edge E_WIDTH+1.
- sum and cout update at E_WIDTH and are valid when done rises.
- Latency from accepting edge to done is WIDTH cycles. Throughput is one result per WIDTH+1 cycles with start held high.
- Operands may change freely after E0.
- sum and cout do not glitch during RUN; only internal shift_s moves.

## Structure
- Shared package `serial_add_pkg`:
  - the state enum (IDLE, RUN, DONE);
  - a cnt-width constant function (clog2 with a minimum of 1);
  - the WIDTH legal-range limit.
- One sub-module, `fa_cell`: a purely combinational full adder with ports a, b, ci in and s, co out, where s=a^b^ci and co=majority(a,b,ci). It is instantiated once. All sequencing lives in serial_add_ctrl.

## Test plan
- WIDTH=8, a=8'hA5, b=8'h3C, cin=0, one-cycle start -> busy high 8 cycles; done one cycle later with sum=8'hE1, cout=0; outputs hold afterward.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1 (full carry ripple through all bits).
- start pulse with a=8'h10, b=8'h20 at step 3 of a run that added 8'h01+8'h02 -> ignored; done reports sum=8'h03, and exactly one done occurs.
- start held high with new operands presented in the DONE cycle -> RUN re-entered with no IDLE cycle; two done strobes 9 cycles apart, each with the correct sum.
- rst_n low at step 4 of a run -> busy, done, sum and cout are 0 immediately, without waiting for clk; no done after release; the next start completes correctly.
- WIDTH=1 build, a=1, b=1, cin=1 -> done one cycle after the accepting edge with sum=1, cout=1.
